// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller for a fetch/decode/execute pipe.
//            Detects load-use hazards, branch-mispredict redirects and
//            memory/multi-cycle freezes. Drives hold (stall) and bubble
//            (flush) controls for the fetch->decode and decode->execute
//            pipeline registers. Keeps saturating stall/flush performance
//            counters and a sticky freeze-timeout flag.
// Ports    :
//    clk, rst                  clock, asynchronous active-high reset
//    dec_rs1/rs2, dec_use_rs*  source operands of the decode instruction
//    ex_valid, ex_mem_read,
//    ex_rd                     execute instruction (load detection)
//    ex_mispredict             branch resolved against its prediction
//    ex_busy, mem_wait         freeze sources
//    stall_fetch/fd/dx         hold controls
//    flush_fd/dx               bubble controls
//    state                     FSM state (RUN=0, FLUSH=1, FREEZE=2)
//    stall_cnt, flush_cnt      saturating performance counters
//    timeout_err               sticky freeze-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int REG_BITS     = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 32,
   parameter int TIMEOUT      = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [REG_BITS-1:0] dec_rs1,
   input  logic [REG_BITS-1:0] dec_rs2,
   input  logic                dec_use_rs1,
   input  logic                dec_use_rs2,
   input  logic                ex_valid,
   input  logic                ex_mem_read,
   input  logic [REG_BITS-1:0] ex_rd,
   input  logic                ex_mispredict,
   input  logic                ex_busy,
   input  logic                mem_wait,
   output logic                stall_fetch,
   output logic                stall_fd,
   output logic                stall_dx,
   output logic                flush_fd,
   output logic                flush_dx,
   output logic [1:0]          state,
   output logic [CNT_W-1:0]    stall_cnt,
   output logic [CNT_W-1:0]    flush_cnt,
   output logic                timeout_err
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_RUN    = 2'd0;
   localparam logic [1:0] c_FLUSH  = 2'd1;
   localparam logic [1:0] c_FREEZE = 2'd2;

   // The countdown never holds more than FLUSH_CYCLES-1.
   localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [REM_W-1:0] c_REM_INIT = REM_W'(FLUSH_CYCLES - 1);
   localparam logic [REM_W-1:0] c_REM_ONE  = REM_W'(1);

   localparam int FRZ_W = $clog2(TIMEOUT + 1);
   localparam logic [FRZ_W-1:0] c_TIMEOUT = FRZ_W'(TIMEOUT);
   localparam logic [FRZ_W-1:0] c_FRZ_ONE = FRZ_W'(1);

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
   localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [1:0]       r_saved;      // state to resume after a freeze
   logic [REM_W-1:0] r_rem;        // flush cycles still owed
   logic [FRZ_W-1:0] r_frz_cnt;    // consecutive freeze cycles, saturating
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             r_timeout;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   logic w_freeze;
   logic w_load_use;
   logic w_rs1_hit;
   logic w_rs2_hit;

   assign w_freeze   = mem_wait | ex_busy;
   assign w_rs1_hit  = dec_use_rs1 & (dec_rs1 == ex_rd);
   assign w_rs2_hit  = dec_use_rs2 & (dec_rs2 == ex_rd);
   // x0 is hardwired zero, so a load targeting it never creates a dependency.
   assign w_load_use = ex_valid & ex_mem_read & (ex_rd != '0) &
                       (w_rs1_hit | w_rs2_hit);

   // While frozen, the cycle that releases the freeze behaves exactly like the
   // state that was interrupted, so decode it as that state.
   logic [1:0] w_eval_state;
   assign w_eval_state = (r_state == c_FREEZE) ? r_saved : r_state;

   // ------------------------------------------------------------------------
   // Next-state and control decode
   // ------------------------------------------------------------------------
   logic [1:0]       w_next_state;
   logic [1:0]       w_next_saved;
   logic [REM_W-1:0] w_next_rem;
   logic             w_flush_accept;

   always_comb begin
      stall_fetch    = 1'b0;
      stall_fd       = 1'b0;
      stall_dx       = 1'b0;
      flush_fd       = 1'b0;
      flush_dx       = 1'b0;
      w_next_state   = c_RUN;
      w_next_saved   = r_saved;
      w_next_rem     = r_rem;
      w_flush_accept = 1'b0;

      if (w_freeze) begin
         // Freeze wins over everything: hold the whole front end and keep the
         // flush countdown untouched until the freeze clears.
         stall_fetch  = 1'b1;
         stall_fd     = 1'b1;
         stall_dx     = 1'b1;
         w_next_state = c_FREEZE;
         w_next_saved = w_eval_state;
      end else begin
         case (w_eval_state)
            c_FLUSH: begin
               // Wrong-path fetches are still arriving; keep bubbling the
               // fetch->decode register. Mispredicts and load-use are
               // ignored here since only bubbles/wrong-path are in flight.
               flush_fd = 1'b1;
               if (r_rem > c_REM_ONE) begin
                  w_next_rem   = r_rem - c_REM_ONE;
                  w_next_state = c_FLUSH;
               end else begin
                  w_next_rem   = '0;
                  w_next_state = c_RUN;
               end
            end
            default: begin
               if (ex_mispredict) begin
                  flush_fd       = 1'b1;
                  flush_dx       = 1'b1;
                  w_flush_accept = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     w_next_state = c_FLUSH;
                     w_next_rem   = c_REM_INIT;
                  end
               end else if (w_load_use) begin
                  // Hold fetch and decode; insert one bubble into execute.
                  stall_fetch = 1'b1;
                  stall_fd    = 1'b1;
                  flush_dx    = 1'b1;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Freeze watchdog
   // ------------------------------------------------------------------------
   logic [FRZ_W-1:0] w_frz_inc;
   assign w_frz_inc = (r_frz_cnt == c_TIMEOUT) ? r_frz_cnt
                                               : (r_frz_cnt + c_FRZ_ONE);

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= c_RUN;
         r_saved     <= c_RUN;
         r_rem       <= '0;
         r_frz_cnt   <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_saved <= w_next_saved;
         r_rem   <= w_next_rem;

         if (w_freeze) begin
            r_frz_cnt <= w_frz_inc;
            if (w_frz_inc == c_TIMEOUT) begin
               r_timeout <= 1'b1;
            end
         end else begin
            r_frz_cnt <= '0;
         end

         if (stall_fetch && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         end
         if (w_flush_accept && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
         end
      end
   end

   assign state       = r_state;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;
   assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. A cycle-level behavioural
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int RB   = 5;
   localparam int FC   = 2;
   localparam int CW   = 4;
   localparam int TMO  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [RB-1:0] dec_rs1, dec_rs2, ex_rd;
   logic          dec_use_rs1, dec_use_rs2, ex_valid, ex_mem_read;
   logic          ex_mispredict, ex_busy, mem_wait;
   logic          stall_fetch, stall_fd, stall_dx, flush_fd, flush_dx;
   logic [1:0]    state;
   logic [CW-1:0] stall_cnt, flush_cnt;
   logic          timeout_err;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(
      .REG_BITS(RB), .FLUSH_CYCLES(FC), .CNT_W(CW), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_mispredict(ex_mispredict), .ex_busy(ex_busy), .mem_wait(mem_wait),
      .stall_fetch(stall_fetch), .stall_fd(stall_fd), .stall_dx(stall_dx),
      .flush_fd(flush_fd), .flush_dx(flush_dx),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // {stall_fetch, stall_fd, stall_dx, flush_fd, flush_dx}
   logic [4:0] ctrl;
   assign ctrl = {stall_fetch, stall_fd, stall_dx, flush_fd, flush_dx};

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model: modes 0=run 1=flush 2=freeze
   // ------------------------------------------------------------------------
   int m_mode, m_resume, m_left, m_frz, m_stall, m_flush;
   bit m_to;

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic bit lu_now();
      return ex_valid && ex_mem_read && (ex_rd != 0) &&
             ((dec_use_rs1 && dec_rs1 == ex_rd) || (dec_use_rs2 && dec_rs2 == ex_rd));
   endfunction

   function automatic logic [4:0] exp_ctrl();
      int eff;
      eff = (m_mode == 2) ? m_resume : m_mode;
      if (mem_wait || ex_busy) return 5'b11100;
      if (eff == 1)            return 5'b00010;
      if (ex_mispredict)       return 5'b00011;
      if (lu_now())            return 5'b11001;
      return 5'b00000;
   endfunction

   always @(posedge clk or posedge rst) begin
      int eff;
      if (rst) begin
         m_mode <= 0; m_resume <= 0; m_left <= 0; m_frz <= 0;
         m_stall <= 0; m_flush <= 0; m_to <= 1'b0;
      end else begin
         eff = (m_mode == 2) ? m_resume : m_mode;
         if (mem_wait || ex_busy) begin
            if (m_mode != 2) m_resume <= m_mode;
            m_mode  <= 2;
            m_stall <= sat(m_stall + 1);
            m_frz   <= (m_frz + 1 > TMO) ? TMO : m_frz + 1;
            if (m_frz + 1 >= TMO) m_to <= 1'b1;
         end else begin
            m_frz <= 0;
            if (eff == 1) begin
               m_left <= m_left - 1;
               m_mode <= (m_left - 1 == 0) ? 0 : 1;
            end else if (ex_mispredict) begin
               m_flush <= sat(m_flush + 1);
               m_left  <= FC - 1;
               m_mode  <= (FC > 1) ? 1 : 0;
            end else begin
               if (lu_now()) m_stall <= sat(m_stall + 1);
               m_mode <= 0;
            end
         end
      end
   end

   // Compare process: outputs are meaningful every cycle, sampled mid-cycle.
   always @(negedge clk) begin
      chk("m_ctrl", int'(ctrl), int'(exp_ctrl()));
      chk("m_state", int'(state), m_mode);
      chk("m_stall_cnt", int'(stall_cnt), m_stall);
      chk("m_flush_cnt", int'(flush_cnt), m_flush);
      chk("m_timeout", int'(timeout_err), int'(m_to));
      chk("m_stall_flush_overlap", int'((stall_fd & flush_fd) | (stall_dx & flush_dx)), 0);
   end

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dec_rs1 = '0; dec_rs2 = '0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = '0;
      ex_mispredict = 1'b0; ex_busy = 1'b0; mem_wait = 1'b0;
   endtask

   task automatic load_use_rs2();
      idle();
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd7;
      dec_rs2 = 5'd7; dec_use_rs2 = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      tick(); tick();
      rst = 1'b0;
      chk("rst_state", int'(state), 0);
      chk("rst_stall_cnt", int'(stall_cnt), 0);
      chk("rst_flush_cnt", int'(flush_cnt), 0);
      chk("rst_ctrl", int'(ctrl), 0);

      // 1: load-use through rs2
      load_use_rs2();
      @(negedge clk); chk("t1_ctrl", int'(ctrl), 5'b11001);
      tick(); idle();
      chk("t1_stall_cnt", int'(stall_cnt), 1);

      // 2: no hazard when ex_rd is x0 or rs2 is not used
      load_use_rs2(); ex_rd = 5'd0; dec_rs2 = 5'd0;
      @(negedge clk); chk("t2_rd0_ctrl", int'(ctrl), 0);
      tick();
      load_use_rs2(); dec_use_rs2 = 1'b0;
      @(negedge clk); chk("t2_nouse_ctrl", int'(ctrl), 0);
      tick();
      // load-use through rs1, then a non-valid execute slot
      idle(); ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
      dec_rs1 = 5'd3; dec_use_rs1 = 1'b1;
      @(negedge clk); chk("t2_rs1_ctrl", int'(ctrl), 5'b11001);
      tick();
      ex_valid = 1'b0;
      @(negedge clk); chk("t2_novalid_ctrl", int'(ctrl), 0);
      tick(); idle();
      chk("t2_stall_cnt", int'(stall_cnt), 2);

      // 3: mispredict, FLUSH ignores further mispredict/load-use
      ex_mispredict = 1'b1;
      @(negedge clk); chk("t3_c0_ctrl", int'(ctrl), 5'b00011);
      tick();
      load_use_rs2(); ex_mispredict = 1'b1;
      @(negedge clk);
      chk("t3_c1_ctrl", int'(ctrl), 5'b00010);
      chk("t3_c1_state", int'(state), 1);
      tick(); idle();
      @(negedge clk);
      chk("t3_c2_ctrl", int'(ctrl), 0);
      chk("t3_c2_state", int'(state), 0);
      chk("t3_flush_cnt", int'(flush_cnt), 1);
      chk("t3_stall_cnt", int'(stall_cnt), 2);
      tick();

      // 4: freeze in the middle of FLUSH
      ex_mispredict = 1'b1;
      tick(); idle(); mem_wait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk("t4_frz_ctrl", int'(ctrl), 5'b11100);
         tick();
      end
      mem_wait = 1'b0;
      @(negedge clk); chk("t4_resume_ctrl", int'(ctrl), 5'b00010);
      tick();
      @(negedge clk); chk("t4_done_ctrl", int'(ctrl), 0);
      chk("t4_stall_cnt", int'(stall_cnt), 5);
      chk("t4_flush_cnt", int'(flush_cnt), 2);
      chk("t4_timeout", int'(timeout_err), 0);
      tick();

      // 5: freeze beats mispredict
      mem_wait = 1'b1; ex_mispredict = 1'b1;
      @(negedge clk); chk("t5_ctrl", int'(ctrl), 5'b11100);
      tick(); idle();
      chk("t5_flush_cnt", int'(flush_cnt), 2);
      chk("t5_state", int'(state), 2);
      tick();
      chk("t5_back_state", int'(state), 0);

      // 6: freeze timeout, sticky
      ex_busy = 1'b1;
      tick(); tick(); tick();
      chk("t6_timeout_early", int'(timeout_err), 0);
      tick(); idle();
      chk("t6_timeout_set", int'(timeout_err), 1);
      tick();
      chk("t6_timeout_sticky", int'(timeout_err), 1);
      chk("t6_stall_cnt", int'(stall_cnt), 10);

      // saturation of both counters
      load_use_rs2();
      for (int i = 0; i < 8; i++) tick();
      idle();
      chk("sat_stall_cnt", int'(stall_cnt), CMAX);
      for (int i = 0; i < 14; i++) begin
         ex_mispredict = 1'b1; tick();
         ex_mispredict = 1'b0; tick();
      end
      chk("sat_flush_cnt", int'(flush_cnt), CMAX);

      // reset mid-FLUSH
      ex_mispredict = 1'b1; tick(); idle();
      chk("rf_pre_state", int'(state), 1);
      rst = 1'b1; #1;
      chk("rf_state", int'(state), 0);
      chk("rf_ctrl", int'(ctrl), 0);
      chk("rf_stall_cnt", int'(stall_cnt), 0);
      chk("rf_flush_cnt", int'(flush_cnt), 0);
      chk("rf_timeout", int'(timeout_err), 0);
      tick(); rst = 1'b0;

      // reset mid-FREEZE
      mem_wait = 1'b1; tick(); tick();
      chk("rz_pre_state", int'(state), 2);
      rst = 1'b1; mem_wait = 1'b0; #1;
      chk("rz_state", int'(state), 0);
      tick(); rst = 1'b0;
      tick();
      chk("rz_after_ctrl", int'(ctrl), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
